// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the RV32I datapath/memory.
// master = the FSM (reads opcode and memory handshake, drives strobes/selects).
// slave  = the datapath/memory side.
interface multicycle_main_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             mem_ready;
  logic             mem_req;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCUpdate;
  logic             Branch;
  logic             RegWrite;
  logic             MemWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       ImmSrc;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, mem_ready,
    output mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, fault, fault_code, instret
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, fault, fault_code, instret
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback over a
// shared memory with a mem_req/mem_ready handshake, memory-timeout and
// illegal-opcode faults, and a retired-instruction counter.
// Optional: define MULTICYCLE_MAIN_FSM_JAL_EN to add the JAL state; otherwise
// opcode 1101111 is treated as illegal.
module multicycle_main_fsm #(
  parameter int CNT_W       = 32,
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_main_fsm_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ,
`ifdef MULTICYCLE_MAIN_FSM_JAL_EN
    S_JAL,
`endif
    S_FAULT
  } state_t;

  state_t           state_reg, state_next;
  logic [TO_W-1:0]  wait_cnt_reg;
  logic [CNT_W-1:0] instret_reg;
  logic [1:0]       fault_code_reg, fault_code_next;

  logic       waiting;   // state is stalled on the memory handshake
  logic       retire;    // leaving this state completes an instruction
  logic       mem_req_raw, ir_write_raw, pc_update_raw, branch_raw;
  logic       reg_write_raw, mem_write_raw;
  logic       adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  // State, wait counter, retire counter and fault code registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      wait_cnt_reg   <= '0;
      instret_reg    <= '0;
      fault_code_reg <= 2'b00;
    end else begin
      state_reg      <= state_next;
      fault_code_reg <= fault_code_next;
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (waiting && !bus.mem_ready)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      if (retire)
        instret_reg <= instret_reg + 1'b1;
    end
  end

  // Next-state and Moore decode of strobes/selects from the current state
  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    waiting         = 1'b0;
    retire          = 1'b0;
    mem_req_raw     = 1'b0;
    ir_write_raw    = 1'b0;
    pc_update_raw   = 1'b0;
    branch_raw      = 1'b0;
    reg_write_raw   = 1'b0;
    mem_write_raw   = 1'b0;
    adr_src         = 1'b0;
    result_src      = 2'b00;
    alu_src_a       = 2'b00;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_req_raw   = 1'b1;
        alu_src_b     = 2'b10;
        result_src    = 2'b10;
        ir_write_raw  = bus.mem_ready;
        pc_update_raw = bus.mem_ready;
        waiting       = 1'b1;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
`ifdef MULTICYCLE_MAIN_FSM_JAL_EN
          OP_JAL:       state_next = S_JAL;
`endif
          default: begin
            state_next      = S_FAULT;
            fault_code_next = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_raw = 1'b1;
        adr_src     = 1'b1;
        waiting     = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_raw   = 1'b1;
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        waiting       = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_next    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch_raw = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MULTICYCLE_MAIN_FSM_JAL_EN
      S_JAL: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b10;
        pc_update_raw = 1'b1;
        state_next    = S_ALUWB;
      end
`endif
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
    // A completing handshake takes priority over the timeout
    if (waiting && !bus.mem_ready && wait_cnt_reg == TO_W'(MEM_TIMEOUT)) begin
      state_next      = S_FAULT;
      fault_code_next = 2'b10;
    end
  end

  // Immediate format select depends only on the opcode, not on the state
  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Strobes are gated by rst so nothing fires while reset is held
  assign bus.mem_req    = mem_req_raw   & ~rst;
  assign bus.IRWrite    = ir_write_raw  & ~rst;
  assign bus.PCUpdate   = pc_update_raw & ~rst;
  assign bus.Branch     = branch_raw    & ~rst;
  assign bus.RegWrite   = reg_write_raw & ~rst;
  assign bus.MemWrite   = mem_write_raw & ~rst;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.fault      = (state_reg == S_FAULT);
  assign bus.fault_code = fault_code_reg;
  assign bus.instret    = instret_reg;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm. A reference model expands each
// instruction into its per-cycle expected control word from the instruction
// timing table; the driver applies inputs and queues expectations, and a
// negedge monitor pops and compares.
module tb_multicycle_main_fsm;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_main_fsm_if #(.CNT_W(CNT_W)) bus();

  multicycle_main_fsm #(.CNT_W(CNT_W), .TO_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst;
    logic             rdy;
    logic [6:0]       op;
    logic [19:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } step_t;

  step_t prog[$];
  step_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  int n_instr = 0;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: return 2'b00;
      OP_SW:       return 2'b01;
      OP_BEQ:      return 2'b10;
      OP_JAL:      return 2'b11;
      default:     return 2'b00;
    endcase
  endfunction

  // Control word: {mem_req,AdrSrc,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,
  //                ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,fault,fault_code}
  function automatic logic [19:0] vec(input logic req, adr, irw, pcu, br, rw, mw,
                                      input logic [1:0] rs, sa, sbs, aop,
                                      input logic [6:0] op, input logic flt,
                                      input logic [1:0] code);
    return {req, adr, irw, pcu, br, rw, mw, rs, sa, sbs, aop, imm_of(op), flt, code};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic r, input logic rdy, input logic [6:0] op, input logic [19:0] c);
    step_t s;
    s.rst = r; s.rdy = rdy; s.op = op; s.ctl = c; s.cnt = CNT_W'(model_cnt);
    prog.push_back(s);
  endtask

  task automatic retire();
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic reset_step(input logic [6:0] op);
    model_cnt = 0;
    step(1'b1, rnd(), op, vec(0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, op, 0, 2'b00));
  endtask

  task automatic fault_tail(input logic [6:0] op, input logic [1:0] code);
    for (int i = 0; i < 4; i++)
      step(1'b0, rnd(), op, vec(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, op, 1, code));
    reset_step(op);
  endtask

  task automatic fetch(input logic [6:0] op, input int w);
    for (int i = 0; i < w; i++)
      step(1'b0, 1'b0, op, vec(1,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, op, 0, 2'b00));
    step(1'b0, 1'b1, op, vec(1,0,1,1,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, op, 0, 2'b00));
  endtask

  task automatic decode_memadr(input logic [6:0] op);
    step(1'b0, rnd(), op, vec(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, op, 0, 2'b00));
    step(1'b0, rnd(), op, vec(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, op, 0, 2'b00));
  endtask

  task automatic aluwb(input logic [6:0] op);
    step(1'b0, rnd(), op, vec(0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, op, 0, 2'b00));
    retire();
  endtask

  // One instruction: fw/mw = mem_ready-low cycles in fetch / data access
  task automatic do_instr(input logic [6:0] op, input int fw, input int mw);
    logic st;
    n_instr++;
    $display("instr %0d op=%b fetch_wait=%0d mem_wait=%0d", n_instr, op, fw, mw);
    fetch(op, fw);
    if (op == OP_LW || op == OP_SW) begin
      decode_memadr(op);
      st = (op == OP_SW);
      for (int i = 0; i < mw; i++)
        step(1'b0, 1'b0, op, vec(1,1,0,0,0,0,st, 2'b00, 2'b00, 2'b00, 2'b00, op, 0, 2'b00));
      step(1'b0, 1'b1, op, vec(1,1,0,0,0,0,st, 2'b00, 2'b00, 2'b00, 2'b00, op, 0, 2'b00));
      if (st) retire();
      else begin
        step(1'b0, rnd(), op, vec(0,0,0,0,0,1,0, 2'b01, 2'b00, 2'b00, 2'b00, op, 0, 2'b00));
        retire();
      end
      return;
    end
    step(1'b0, rnd(), op, vec(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, op, 0, 2'b00));
    case (op)
      OP_R: begin
        step(1'b0, rnd(), op, vec(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, op, 0, 2'b00));
        aluwb(op);
      end
      OP_I: begin
        step(1'b0, rnd(), op, vec(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, op, 0, 2'b00));
        aluwb(op);
      end
      OP_BEQ: begin
        step(1'b0, rnd(), op, vec(0,0,0,0,1,0,0, 2'b00, 2'b10, 2'b00, 2'b01, op, 0, 2'b00));
        retire();
      end
`ifdef MULTICYCLE_MAIN_FSM_JAL_EN
      OP_JAL: begin
        step(1'b0, rnd(), op, vec(0,0,0,1,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, op, 0, 2'b00));
        aluwb(op);
      end
`endif
      default: fault_tail(op, 2'b01);
    endcase
  endtask

  task automatic pick_random(output logic [6:0] op);
    int k;
`ifdef MULTICYCLE_MAIN_FSM_JAL_EN
    k = $urandom_range(0, 5);
`else
    k = $urandom_range(0, 4);
`endif
    case (k)
      0: op = OP_LW;
      1: op = OP_SW;
      2: op = OP_R;
      3: op = OP_I;
      4: op = OP_BEQ;
      default: op = OP_JAL;
    endcase
  endtask

  task automatic build();
    logic [6:0] op;
    reset_step(OP_R);
    do_instr(OP_R, 0, 0);
    for (int i = 0; i < 14; i++) begin
      pick_random(op);
      do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    do_instr(OP_BEQ, 0, 0);               // instret 15 -> wraps to 0
    for (int i = 0; i < 40; i++) begin
      pick_random(op);
      do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    do_instr(OP_LW, 0, 3);
    do_instr(OP_LW, MEM_TIMEOUT, MEM_TIMEOUT);  // ready on the last tolerated cycle
    do_instr(OP_SW, MEM_TIMEOUT, MEM_TIMEOUT);
    // store that never completes: times out after MEM_TIMEOUT+1 low cycles
    $display("instr timeout sw");
    fetch(OP_SW, 0);
    decode_memadr(OP_SW);
    for (int i = 0; i <= MEM_TIMEOUT; i++)
      step(1'b0, 1'b0, OP_SW, vec(1,1,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, OP_SW, 0, 2'b00));
    fault_tail(OP_SW, 2'b10);
    do_instr(OP_R, 0, 0);
    do_instr(OP_BAD, 1, 0);
    do_instr(OP_I, 0, 0);
    // reset in the middle of a load's data access
    $display("instr lw aborted by reset");
    fetch(OP_LW, 0);
    decode_memadr(OP_LW);
    step(1'b0, 1'b0, OP_LW, vec(1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, OP_LW, 0, 2'b00));
    step(1'b0, 1'b0, OP_LW, vec(1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, OP_LW, 0, 2'b00));
    reset_step(OP_LW);
    do_instr(OP_R, 0, 0);
    do_instr(OP_JAL, 0, 0);
    do_instr(OP_R, 0, 0);
  endtask

  // Driver: apply one step per cycle and queue its expectation
  initial begin
    step_t s;
    bus.op = OP_R;
    bus.mem_ready = 1'b0;
    build();
    while (prog.size() > 0) begin
      s = prog.pop_front();
      @(posedge clk);
      #1;
      rst = s.rst;
      bus.mem_ready = s.rdy;
      bus.op = s.op;
      sb.push_back(s);
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: compare the DUT's outputs against the oldest expectation
  always @(negedge clk) begin
    step_t e;
    logic [19:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCUpdate, bus.Branch,
             bus.RegWrite, bus.MemWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
             bus.ALUOp, bus.ImmSrc, bus.fault, bus.fault_code};
      checks++;
      if (got !== e.ctl || bus.instret !== e.cnt) begin
        errors++;
        $display("FAIL ctl_check t=%0t op=%b rst=%b ctl=%h required=%h instret=%0d required=%0d",
                 $time, e.op, e.rst, got, e.ctl, bus.instret, e.cnt);
      end
    end
  end
endmodule
